// File: rtl/vector_argmax_seq_pkg.sv
// rtl/vector_argmax_seq_pkg.sv - shared FSM encodings and IEEE-754 field constants
package vector_argmax_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] EXP_MASK  = 32'h7F80_0000;
    localparam logic [31:0] MANT_MASK = 32'h007F_FFFF;
    localparam int          SIGN_BIT  = 31;
    localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

endpackage

// File: rtl/vector_argmax_seq_float_greater.sv
// rtl/vector_argmax_seq_float_greater.sv - strict a > b on single-precision bit patterns, NaN ranked lowest
module float_greater
    import vector_argmax_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    logic        a_nan;
    logic        b_nan;
    logic        both_zero;
    logic [31:0] a_key;
    logic [31:0] b_key;

    always_comb begin
        a_nan     = ((a & EXP_MASK) == EXP_MASK) && ((a & MANT_MASK) != 32'd0);
        b_nan     = ((b & EXP_MASK) == EXP_MASK) && ((b & MANT_MASK) != 32'd0);
        both_zero = ((a & ~SIGN_MASK) == 32'd0) && ((b & ~SIGN_MASK) == 32'd0);
        // Flip negatives and set the sign of positives so unsigned order equals numeric order.
        a_key = a[SIGN_BIT] ? ~a : (a | SIGN_MASK);
        b_key = b[SIGN_BIT] ? ~b : (b | SIGN_MASK);
        gt    = 1'b0;
        if (a_nan) begin
            gt = 1'b0;
        end else if (b_nan) begin
            gt = 1'b1;
        end else if (both_zero) begin
            gt = 1'b0;
        end else begin
            gt = (a_key > b_key);
        end
    end

endmodule

// File: rtl/vector_argmax_seq.sv
// rtl/vector_argmax_seq.sv - sequential argmax over a snapshot of a float vector, one element per cycle
module vector_argmax_seq
    import vector_argmax_seq_pkg::*;
#(
    parameter int VLEN  = 10,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*VLEN-1:0]   in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     index,
    output logic [31:0]          max_value
);

    localparam int                CNT_W = $clog2(VLEN + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(VLEN - 1);

    state_t               state_q, state_d;
    logic [32*VLEN-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          best_q, best_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [31:0]          max_q, max_d;

    logic [31:0]          cand;
    logic                 cand_gt;
    logic                 accept;
    logic [31:0]          nxt_best;
    logic [IDX_W-1:0]     nxt_idx;

    assign cand   = snap_q[{cnt_q, 5'b0} +: 32];
    assign accept = start && (state_q != ST_SCAN);

    float_greater u_gt (
        .a  (cand),
        .b  (best_q),
        .gt (cand_gt)
    );

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        index_d    = index_q;
        max_d      = max_q;
        nxt_best   = best_q;
        nxt_idx    = best_idx_q;
        if (cand_gt) begin
            nxt_best = cand;
            nxt_idx  = cnt_q[IDX_W-1:0];
        end

        if (accept) begin
            snap_d     = in;
            best_d     = in[31:0];
            best_idx_d = '0;
            cnt_d      = CNT_W'(1);
            if (VLEN == 1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                index_d = '0;
                max_d   = in[31:0];
            end else begin
                state_d = ST_SCAN;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SCAN: begin
                    best_d     = nxt_best;
                    best_idx_d = nxt_idx;
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        index_d = nxt_idx;
                        max_d   = nxt_best;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        busy_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            index_q    <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            index_q    <= index_d;
            max_q      <= max_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign index     = index_q;
    assign max_value = max_q;

endmodule

// File: tb/tb_vector_argmax_seq.sv
// tb/tb_vector_argmax_seq.sv - directed self-checking bench for vector_argmax_seq
module tb_vector_argmax_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in4;
    logic         start4;
    logic         busy4;
    logic         done4;
    logic [1:0]   index4;
    logic [31:0]  max4;
    logic [31:0]  in1;
    logic         start1;
    logic         busy1;
    logic         done1;
    logic [0:0]   index1;
    logic [31:0]  max1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_argmax_seq #(.VLEN(4), .IDX_W(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in        (in4),
        .start     (start4),
        .busy      (busy4),
        .done      (done4),
        .index     (index4),
        .max_value (max4)
    );

    vector_argmax_seq #(.VLEN(1), .IDX_W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in        (in1),
        .start     (start1),
        .busy      (busy1),
        .done      (done1),
        .index     (index1),
        .max_value (max1)
    );

    // Pulse start4 for one cycle and record done/busy timing over the next 8 cycles.
    task automatic run4(input logic [127:0] v, output int done_at, output int done_cnt,
                        output logic [8:0] busy_mask);
        done_at   = 0;
        done_cnt  = 0;
        busy_mask = '0;
        @(negedge clk);
        in4    = v;
        start4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start4 = 1'b0;
            if (done4) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            busy_mask[k] = busy4;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, index4, max4} !== 36'd0) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=0", {busy4, done4, index4, max4});
        end
        checks++;
        if ({busy1, done1, index1, max1} !== 35'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=0", {busy1, done1, index1, max1});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int d_at, d_cnt;
        logic [8:0] bm;
        run4({32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F000000}, d_at, d_cnt, bm);
        checks++;
        if (d_at !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", d_at); end
        checks++;
        if (d_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", d_cnt); end
        checks++;
        if (bm !== 9'h00E) begin failures++; $display("FAIL basic_busy_mask got=%h exp=00e", bm); end
        checks++;
        if (index4 !== 2'd1) begin failures++; $display("FAIL basic_index got=%0d exp=1", index4); end
        checks++;
        if (max4 !== 32'h40000000) begin failures++; $display("FAIL basic_max got=%h exp=40000000", max4); end
    endtask

    task automatic test_ties_zero;
        int d_at, d_cnt;
        logic [8:0] bm;
        run4({32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3F800000}, d_at, d_cnt, bm);
        checks++;
        if (index4 !== 2'd0 || max4 !== 32'h3F800000) begin
            failures++; $display("FAIL tie_lowest got=%0d/%h exp=0/3f800000", index4, max4);
        end
        run4({32'hBF800000, 32'hBF800000, 32'h80000000, 32'h00000000}, d_at, d_cnt, bm);
        checks++;
        if (index4 !== 2'd0 || max4 !== 32'h00000000) begin
            failures++; $display("FAIL zero_tie got=%0d/%h exp=0/00000000", index4, max4);
        end
        run4({32'h00000001, 32'h80000000, 32'h00000000, 32'h807FFFFF}, d_at, d_cnt, bm);
        checks++;
        if (index4 !== 2'd3 || max4 !== 32'h00000001) begin
            failures++; $display("FAIL denormal got=%0d/%h exp=3/00000001", index4, max4);
        end
    endtask

    task automatic test_nan;
        int d_at, d_cnt;
        logic [8:0] bm;
        run4({32'h7FC00000, 32'hFF800000, 32'hBF800000, 32'h7FC00000}, d_at, d_cnt, bm);
        checks++;
        if (index4 !== 2'd1 || max4 !== 32'hBF800000) begin
            failures++; $display("FAIL nan_mixed got=%0d/%h exp=1/bf800000", index4, max4);
        end
        run4({32'h7F800001, 32'hFFC00000, 32'h7FC00001, 32'h7FC00000}, d_at, d_cnt, bm);
        checks++;
        if (index4 !== 2'd0 || max4 !== 32'h7FC00000) begin
            failures++; $display("FAIL nan_all got=%0d/%h exp=0/7fc00000", index4, max4);
        end
    endtask

    task automatic test_ignore_busy;
        int d_at = 0;
        int d_cnt = 0;
        @(negedge clk);
        in4    = {32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F000000};
        start4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done4) begin
                d_cnt++;
                if (d_at == 0) d_at = k;
            end
            if (k == 1) start4 = 1'b0;
            if (k == 2) begin
                in4    = {32'h7F000000, 32'h00000000, 32'h00000000, 32'h00000000};
                start4 = 1'b1;
            end
            if (k == 3) start4 = 1'b0;
        end
        checks++;
        if (d_cnt !== 1 || d_at !== 4) begin
            failures++; $display("FAIL ignore_done got=%0d@%0d exp=1@4", d_cnt, d_at);
        end
        checks++;
        if (index4 !== 2'd1 || max4 !== 32'h40000000) begin
            failures++; $display("FAIL ignore_result got=%0d/%h exp=1/40000000", index4, max4);
        end
    endtask

    task automatic test_reset_mid;
        int d_cnt = 0;
        int d_at;
        logic [8:0] bm;
        @(negedge clk);
        in4    = {32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000};
        start4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done4) d_cnt++;
            if (k == 1) start4 = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
        end
        checks++;
        if (d_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", d_cnt); end
        checks++;
        if ({busy4, index4, max4} !== 35'd0) begin
            failures++; $display("FAIL abort_outputs got=%h exp=0", {busy4, index4, max4});
        end
        run4({32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F000000}, d_at, d_cnt, bm);
        checks++;
        if (d_at !== 4 || index4 !== 2'd1 || max4 !== 32'h40000000) begin
            failures++; $display("FAIL after_reset got=%0d %0d/%h exp=4 1/40000000", d_at, index4, max4);
        end
    endtask

    task automatic test_vlen1_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h3F800000;
        vals[1] = 32'h40000000;
        vals[2] = 32'hC0000000;
        @(negedge clk);
        in1    = vals[0];
        start1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || index1 !== 1'b0 || max1 !== vals[k-1]) begin
                failures++;
                $display("FAIL vlen1_cycle%0d got=%b%b %0d/%h exp=10 0/%h", k, done1, busy1, index1, max1, vals[k-1]);
            end
            if (k < 3) in1 = vals[k];
            else start1 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || max1 !== 32'hC0000000) begin
            failures++; $display("FAIL vlen1_hold got=%b/%h exp=0/c0000000", done1, max1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        in4    = '0;
        in1    = '0;
        test_reset;
        test_basic;
        test_ties_zero;
        test_nan;
        test_ignore_busy;
        test_reset_mid;
        test_vlen1_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_argmax_seq.md
VECTOR_ARGMAX_SEQ -- requirements
Module: vector_argmax_seq

Interface
REQ-001 Parameter VLEN, default 10: number of 32-bit IEEE-754 single-precision elements in the input vector; legal range 1..1024.
REQ-002 Parameter IDX_W, default 4: width of the index output; SHALL equal max(1, ceil(log2(VLEN))).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in  input  32*VLEN  packed vector; element i occupies bits [32*i +: 32].
REQ-006 start  input  1  request to scan `in`; connects directly to an upstream layer's done output.
REQ-007 busy  output  1  high while a scan is in progress.
REQ-008 done  output  1  one-cycle pulse; index and max_value are valid from this cycle on.
REQ-009 index  output  IDX_W  position of the maximum element.
REQ-010 max_value  output  32  bit pattern of the maximum element.

Function
REQ-011 FSM states SHALL be IDLE, SCAN and DONE.
- IDLE -> SCAN on accept when VLEN>1.
- IDLE -> DONE on accept when VLEN==1.
- SCAN -> DONE after element VLEN-1 is compared.
- DONE -> IDLE unconditionally, or DONE -> SCAN/DONE on a back-to-back accept.
REQ-012 start SHALL be accepted only in IDLE or DONE; while busy, start SHALL be ignored with no effect.
REQ-013 On accept, the block SHALL snapshot all of `in` into an internal register; later changes to `in` SHALL NOT affect the scan in progress.
REQ-014 On accept, the block SHALL load best = element 0, best_idx = 0 and element counter = 1.
REQ-015 In SCAN, the block SHALL compare exactly one element per cycle, in ascending index order.
REQ-016 Latency: if start is accepted in cycle T, done SHALL be high in exactly cycle T+VLEN (T+1 when VLEN==1).
REQ-017 busy SHALL be high from cycle T+1 through T+VLEN-1; it SHALL be low in IDLE and DONE.
REQ-018 index and max_value SHALL be updated only on the edge entering DONE.
REQ-019 index and max_value SHALL then hold until the next done.
REQ-020 Ordering: candidate replaces best only if candidate > best (strict); ties SHALL keep the lower index.
REQ-021 Comparison SHALL use IEEE-754 sign-magnitude order: -inf < negatives < -0 == +0 < positives < +inf; denormals SHALL be compared exactly.
REQ-022 NaN (exponent all ones, mantissa nonzero) SHALL rank below every non-NaN value.
REQ-023 If every element is NaN, the result SHALL be index 0 with max_value equal to element 0.
REQ-024 The counter SHALL be wide enough to reach VLEN without wrap-around; it SHALL NOT wrap during a scan.
REQ-025 start held high continuously SHALL produce one scan per VLEN cycles, each on a fresh snapshot taken in the DONE cycle.

Reset
REQ-026 While rst is high at a rising edge, state SHALL become IDLE.
REQ-027 On that same edge, busy, done, index and max_value SHALL become 0 and the snapshot and counter SHALL be cleared.
REQ-028 rst SHALL take priority over start.
REQ-029 rst asserted mid-scan SHALL abort the scan; no done pulse SHALL follow for the aborted scan.
REQ-030 The first start accepted after rst deasserts SHALL behave exactly as after power-up.

Structure
REQ-031 A shared constants package SHALL hold the FSM state encodings and the IEEE-754 field constants: exponent mask 0x7F800000, mantissa mask 0x007FFFFF, sign bit 31.
REQ-032 One combinational sub-module, float_greater, SHALL implement REQ-020 to REQ-022.
- Inputs a and b, 32 bits each; output gt, 1 bit.
- It SHALL be instantiated once and shared across all scan cycles.
REQ-033 Element selection SHALL use an indexed part-select of the snapshot by the counter; there SHALL be no per-element comparator array.

Verification
REQ-034 VLEN=4, in = {0.5, 2.0, -1.0, 1.0} (elements 0..3: 3F000000, 40000000, BF800000, 3F800000), start pulse in cycle T -> done only in T+4, index=1, max_value=40000000, busy high in T+1..T+3.
REQ-035 VLEN=4, elements {1.0, 1.0, 0.5, 1.0}, plus a second case {+0, -0, ...} with all remaining elements BF800000 -> first case index=0 (tie keeps lowest); second case index=0, max_value=00000000.
REQ-036 VLEN=4, elements {7FC00000 NaN, BF800000, FF800000 -inf, 7FC00000} -> index=1, max_value=BF800000; all-NaN vector -> index=0, max_value=7FC00000.
REQ-037 VLEN=4, change `in` and pulse start again during busy -> the second start is ignored; result reflects the original snapshot; exactly one done pulse.
REQ-038 VLEN=4, rst asserted in cycle T+2 of a scan -> done never pulses, outputs read 0; a new start produces a correct result with latency 4.
REQ-039 VLEN=1 with start held high for 3 cycles -> done high in 3 consecutive cycles; index stays 0; max_value tracks element 0 of each snapshot.
